spi_stream_responder: RTL and testbench

- Synthesizable SPI mode-0 responder: the device end of the link that DATA_FSM initiates.
- Receives a one-byte read command on MOSI.
- Answers on MISO with idle 0x00 bytes, then a 0xFF data header, then a fixed-length payload pulled from a byte-stream source.
- Used as an on-chip stand-in for the storage device during bring-up and loopback, and as the reusable model in video/audio acquisition benches.

---
 rtl/spi_stream_responder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_spi_stream_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_responder.sv
// spi_stream_responder: SPI mode-0 device that answers a read command with
// latency bytes, a header token and a fixed-length payload from a byte stream.
//
// Optional feature: define STREAM_CRC_EN to append a CRC-16-CCITT trailer
// (poly 0x1021, init 0x0000, MSB first) computed over the payload bytes.
//
// Ports:
//   CLK_40      in   system clock, all flops on its rising edge
//   reset       in   asynchronous active-high reset
//   SPI_clk     in   SPI serial clock from the initiator (oversampled)
//   chip_select in   active-low select from the initiator
//   MOSI        in   command data, sampled on SPI_clk rising edges
//   MISO        out  response data, updated after SPI_clk falling edges
//   src_data    in   next payload byte
//   src_valid   in   src_data is valid
//   src_ready   out  one-cycle fetch strobe; byte consumed when valid&ready
//   busy        out  high whenever the responder is not idle
//   frame_sent  out  one-cycle pulse after the final bit of a complete frame
//   underrun    out  sticky; a payload byte was needed while src_valid was low
module spi_stream_responder #(
    parameter logic [7:0] CMD_READ      = 8'h52,
    parameter int         LATENCY_BYTES = 4,
    parameter logic [7:0] HEADER_BYTE   = 8'hFF,
    parameter int         PAYLOAD_LEN   = 512
) (
    input  logic       CLK_40,
    input  logic       reset,
    input  logic       SPI_clk,
    input  logic       chip_select,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic       busy,
    output logic       frame_sent,
    output logic       underrun
);

    localparam int PW = $clog2(PAYLOAD_LEN + 1);
    localparam int LW = (LATENCY_BYTES > 1) ? $clog2(LATENCY_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, CMD, WAIT, HEADER, DATA, CRC, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic            sclk_prev_q, cs_prev_q;
    logic [2:0]      bit_q, bit_d;
    logic [6:0]      cmd_q, cmd_d;
    logic [7:0]      shift_q, shift_d;
    logic            miso_q;
    logic            load_q, load_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [PW-1:0]   pay_q, pay_d;
    logic            frame_q, frame_d;
    logic            under_q, under_d;
`ifdef STREAM_CRC_EN
    logic [15:0]     crc_q, crc_d;
    logic [1:0]      crc_cnt_q, crc_cnt_d;
`endif

    logic       sclk_s, cs_s, mosi_s, rise, fall, cs_fall, active, last_rise;
    logic [7:0] cmd_byte, fetch_byte;

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign rise      = sclk_s & ~sclk_prev_q;
    assign fall      = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign active    = (state_q == CMD) || (state_q == WAIT) || (state_q == HEADER) ||
                       (state_q == DATA) || (state_q == CRC);
    assign last_rise = active && rise && (bit_q == 3'd7);
    assign cmd_byte  = {cmd_q, mosi_s};
    assign fetch_byte = src_valid ? src_data : 8'h00;

    assign MISO       = miso_q;
    assign busy       = state_q != IDLE;
    assign frame_sent = frame_q;
    assign underrun   = under_q;

`ifdef STREAM_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction
`endif

    // Chip select resets to the deselected level so a select held low across
    // reset release still produces the falling edge that opens a frame.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_sync_q   <= 2'b11;
            cs_prev_q   <= 1'b1;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], SPI_clk};
            sclk_prev_q <= sclk_s;
            cs_sync_q   <= {cs_sync_q[0], chip_select};
            cs_prev_q   <= cs_s;
            mosi_sync_q <= {mosi_sync_q[0], MOSI};
        end
    end

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            cmd_q     <= '0;
            shift_q   <= '0;
            miso_q    <= 1'b0;
            load_q    <= 1'b0;
            lat_q     <= '0;
            pay_q     <= '0;
            frame_q   <= 1'b0;
            under_q   <= 1'b0;
`ifdef STREAM_CRC_EN
            crc_q     <= '0;
            crc_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            cmd_q     <= cmd_d;
            shift_q   <= shift_d;
            miso_q    <= shift_d[7];
            load_q    <= load_d;
            lat_q     <= lat_d;
            pay_q     <= pay_d;
            frame_q   <= frame_d;
            under_q   <= under_d;
`ifdef STREAM_CRC_EN
            crc_q     <= crc_d;
            crc_cnt_q <= crc_cnt_d;
`endif
        end
    end

    // State changes happen on the rise of bit 7; the byte for the new state
    // is loaded on the following fall strobe (load_q marks that pending load).
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        cmd_d     = cmd_q;
        shift_d   = shift_q;
        load_d    = load_q;
        lat_d     = lat_q;
        pay_d     = pay_q;
        frame_d   = 1'b0;
        under_d   = under_q;
        src_ready = 1'b0;
`ifdef STREAM_CRC_EN
        crc_d     = crc_q;
        crc_cnt_d = crc_cnt_q;
`endif
        if (active && rise)
            bit_d = bit_q + 3'd1;
        if (active && fall)
            shift_d = {shift_q[6:0], 1'b0};
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = CMD;
                    bit_d   = '0;
                end
            end
            CMD: begin
                if (rise) begin
                    cmd_d = cmd_byte[6:0];
                    if (bit_q == 3'd7) begin
                        state_d = (cmd_byte == CMD_READ) ?
                                  ((LATENCY_BYTES == 0) ? HEADER : WAIT) : DONE;
                        load_d  = cmd_byte == CMD_READ;
                    end
                end
            end
            WAIT: begin
                if (last_rise) begin
                    load_d = 1'b1;
                    lat_d  = lat_q + LW'(1);
                    if (lat_q == LW'(LATENCY_BYTES - 1)) begin
                        state_d = HEADER;
                        lat_d   = '0;
                    end
                end
            end
            HEADER: begin
                if (last_rise) begin
                    load_d  = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (last_rise) begin
                    if (pay_q == PW'(PAYLOAD_LEN)) begin
`ifdef STREAM_CRC_EN
                        state_d = CRC;
                        load_d  = 1'b1;
`else
                        state_d = DONE;
                        frame_d = 1'b1;
                        shift_d = '0;
`endif
                    end else begin
                        load_d = 1'b1;
                    end
                end
            end
`ifdef STREAM_CRC_EN
            CRC: begin
                if (last_rise) begin
                    if (crc_cnt_q == 2'd2) begin
                        state_d = DONE;
                        frame_d = 1'b1;
                        shift_d = '0;
                    end else begin
                        load_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
        if (fall && load_q) begin
            load_d = 1'b0;
            case (state_q)
                WAIT:   shift_d = 8'h00;
                HEADER: shift_d = HEADER_BYTE;
                DATA: begin
                    src_ready = 1'b1;
                    shift_d   = fetch_byte;
                    under_d   = under_q | ~src_valid;
                    pay_d     = pay_q + PW'(1);
`ifdef STREAM_CRC_EN
                    crc_d     = crc_step(crc_q, fetch_byte);
`endif
                end
`ifdef STREAM_CRC_EN
                CRC: begin
                    shift_d   = (crc_cnt_q == 2'd0) ? crc_q[15:8] : crc_q[7:0];
                    crc_cnt_d = crc_cnt_q + 2'd1;
                end
`endif
                default: ;
            endcase
        end
        // Deselect aborts from any state; a fetch strobed this cycle still
        // completes on the source side.
        if (cs_s) begin
            state_d   = IDLE;
            bit_d     = '0;
            cmd_d     = '0;
            shift_d   = '0;
            load_d    = 1'b0;
            lat_d     = '0;
            pay_d     = '0;
            frame_d   = 1'b0;
`ifdef STREAM_CRC_EN
            crc_d     = '0;
            crc_cnt_d = '0;
`endif
        end
    end

endmodule

// File: tb/tb_spi_stream_responder.sv
// tb_spi_stream_responder: directed self-checking bench for spi_stream_responder.
module tb_spi_stream_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, src_ready, busy, frame_sent, underrun, src_valid;
    logic [7:0] src_data;
    logic       miso2;

    int rdy_cnt = 0;
    int frm_cnt = 0;
    int base = 0;
    int drop_at = -1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign src_data  = 8'(rdy_cnt - base + 1);
    assign src_valid = rdy_cnt != drop_at;

    always @(posedge clk) begin
        rdy_cnt <= rdy_cnt + int'(src_ready);
        frm_cnt <= frm_cnt + int'(frame_sent);
    end

    spi_stream_responder #(.PAYLOAD_LEN(16)) dut (
        .CLK_40(clk), .reset(rst), .SPI_clk(sclk), .chip_select(cs), .MOSI(mosi),
        .MISO(miso), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .busy(busy), .frame_sent(frame_sent), .underrun(underrun)
    );

`ifdef STREAM_CRC_EN
    logic       c_ready, c_busy, c_frame, c_under;
    logic [7:0] c_data;
    int c_cnt = 0;
    int c_frm = 0;
    int c_base = 0;
    assign c_data = 8'(8'h31 + c_cnt - c_base);
    always @(posedge clk) begin
        c_cnt <= c_cnt + int'(c_ready);
        c_frm <= c_frm + int'(c_frame);
    end
    spi_stream_responder #(.PAYLOAD_LEN(9)) dut_crc (
        .CLK_40(clk), .reset(rst), .SPI_clk(sclk), .chip_select(cs), .MOSI(mosi),
        .MISO(miso2), .src_data(c_data), .src_valid(1'b1), .src_ready(c_ready),
        .busy(c_busy), .frame_sent(c_frame), .underrun(c_under)
    );
`else
    assign miso2 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rx2);
        rx = 8'h00;
        rx2 = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            repeat (8) @(negedge clk);
            rx  = {rx[6:0], miso};
            rx2 = {rx2[6:0], miso2};
            sclk = 1'b1;
            repeat (8) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic sel(input logic v);
        cs = v;
        repeat (8) @(negedge clk);
    endtask

    logic [7:0] rx [0:22];
    logic [7:0] rx2 [0:22];
    logic [7:0] d0, d1;
    int fb, fpre, fmid, rb;
`ifdef STREAM_CRC_EN
    int cfb;
`endif

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_miso", miso, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_frame", frame_sent, 0);
        chk("rst_underrun", underrun, 0);

        // idle immunity: clock toggling with select high
        for (int i = 0; i < 16; i++) begin
            sclk = ~sclk;
            repeat (4) @(negedge clk);
            chk("idle_miso", miso, 0);
            chk("idle_busy", busy, 0);
        end
        sclk = 1'b0;
        repeat (4) @(negedge clk);

        // basic read
        base = rdy_cnt;
        fb = frm_cnt;
        rb = rdy_cnt;
`ifdef STREAM_CRC_EN
        c_base = c_cnt;
        cfb = c_frm;
`endif
        sel(1'b0);
        spi_byte(8'h52, d0, d1);
        for (int i = 0; i < 23; i++) begin
            if (i == 20) fpre = frm_cnt;
            spi_byte(8'h00, rx[i], rx2[i]);
            if (i == 20) fmid = frm_cnt;
        end
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("basic_latency", rx[i], 0);
        chk("basic_header", rx[4], 8'hFF);
        for (int i = 0; i < 16; i++) chk("basic_payload", rx[5+i], i + 1);
        chk("basic_frame_before_last", fpre - fb, 0);
`ifdef STREAM_CRC_EN
        chk("basic_frame_after_last", fmid - fb, 0);
`else
        chk("basic_frame_after_last", fmid - fb, 1);
        chk("basic_tail0", rx[21], 0);
        chk("basic_tail1", rx[22], 0);
`endif
        chk("basic_frames", frm_cnt - fb, 1);
        chk("basic_ready_pulses", rdy_cnt - rb, 16);
        chk("basic_underrun", underrun, 0);
        chk("basic_busy_done", busy, 1);
`ifdef STREAM_CRC_EN
        for (int i = 0; i < 9; i++) chk("crc_payload", rx2[5+i], 8'h31 + i);
        chk("crc_hi", rx2[14], 8'h31);
        chk("crc_lo", rx2[15], 8'hC3);
        chk("crc_frames", c_frm - cfb, 1);
`endif
        sel(1'b1);
        chk("basic_busy_deselect", busy, 0);

        // bad command
        fb = frm_cnt;
        rb = rdy_cnt;
        sel(1'b0);
        spi_byte(8'h11, d0, d1);
        chk("bad_cmd_miso", d0, 0);
        for (int i = 0; i < 8; i++) begin
            spi_byte(8'h00, rx[i], rx2[i]);
            chk("bad_miso", rx[i], 0);
        end
        chk("bad_ready", rdy_cnt - rb, 0);
        chk("bad_frame", frm_cnt - fb, 0);
        chk("bad_busy", busy, 1);
        sel(1'b1);
        chk("bad_busy_deselect", busy, 0);

        // mid-payload abort then restart
        base = rdy_cnt;
        fb = frm_cnt;
        sel(1'b0);
        spi_byte(8'h52, d0, d1);
        for (int i = 0; i < 10; i++) spi_byte(8'h00, rx[i], rx2[i]);
        chk("abort_byte5", rx[9], 5);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_miso", miso, 0);
        repeat (8) @(negedge clk);
        chk("abort_frame", frm_cnt - fb, 0);
        base = rdy_cnt;
        sel(1'b0);
        spi_byte(8'h52, d0, d1);
        for (int i = 0; i < 6; i++) spi_byte(8'h00, rx[i], rx2[i]);
        chk("restart_latency", rx[3], 0);
        chk("restart_header", rx[4], 8'hFF);
        chk("restart_first", rx[5], 1);
        sel(1'b1);

        // underrun on payload byte 3
        base = rdy_cnt;
        drop_at = rdy_cnt + 2;
        sel(1'b0);
        spi_byte(8'h52, d0, d1);
        for (int i = 0; i < 23; i++) spi_byte(8'h00, rx[i], rx2[i]);
        drop_at = -1;
        chk("under_byte2", rx[6], 2);
        chk("under_byte3", rx[7], 0);
        chk("under_byte4", rx[8], 4);
        chk("under_flag", underrun, 1);
        sel(1'b1);
        base = rdy_cnt;
        sel(1'b0);
        spi_byte(8'h52, d0, d1);
        for (int i = 0; i < 6; i++) spi_byte(8'h00, rx[i], rx2[i]);
        chk("under_next_first", rx[5], 1);
        chk("under_sticky", underrun, 1);
        sel(1'b1);
        chk("under_sticky_idle", underrun, 1);

        // asynchronous reset mid-DATA
        base = rdy_cnt;
        sel(1'b0);
        spi_byte(8'h52, d0, d1);
        for (int i = 0; i < 8; i++) spi_byte(8'h00, rx[i], rx2[i]);
        chk("pre_reset_busy", busy, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        cs = 1'b1;
        #1;
        chk("async_miso", miso, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", src_ready, 0);
        chk("async_frame", frame_sent, 0);
        chk("async_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_reset_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
